// File: rtl/acl_pkg.sv
// acl_pkg: shared state encoding, command bytes and burst lengths for the ADXL362 sequencer.
package acl_pkg;

    typedef enum logic [2:0] {
        STARTUP,
        INIT,
        GAP_I,
        IDLE,
        READ,
        PUBLISH,
        GAP_R
    } acl_state_e;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam int         INIT_LEN  = 3;
    localparam int         READ_LEN  = 8;

endpackage

// File: rtl/acl_rate_timer.sv
// acl_rate_timer: free-running 0..PERIOD-1 counter, one-cycle tick at wrap while running.
module acl_rate_timer #(
    parameter int unsigned PERIOD = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic tick_o
);

    logic [31:0] cnt_q;
    logic        wrap;

    assign wrap   = cnt_q == 32'(PERIOD - 1);
    assign tick_o = run_i && wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (run_i) cnt_q <= wrap ? '0 : cnt_q + 32'd1;
    end

endmodule

// File: rtl/acl_sample_sequencer.sv
// acl_sample_sequencer: ADXL362 init write, then periodic XDATA_L..ZDATA_H burst reads
// over the SPI byte interface, publishing sign-extended 12-bit X/Y/Z samples.
module acl_sample_sequencer
    import acl_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD  = 1000000,
    parameter int unsigned STARTUP_CYCLES = 1000000,
    parameter int unsigned GAP_CYCLES     = 16384,
    parameter logic [7:0]  REG_POWER_CTL  = 8'h2D,
    parameter logic [7:0]  POWER_CTL_VAL  = 8'h02,
    parameter logic [7:0]  REG_XDATA_L    = 8'h0E
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [7:0]  send_data,
    output logic        begin_transmission,
    input  logic        end_transmission,
    input  logic [7:0]  recieved_data,
    output logic [11:0] acl_x,
    output logic [11:0] acl_y,
    output logic [11:0] acl_z,
    output logic        sample_valid,
    output logic        init_done,
    output logic        sample_overrun
);

    acl_state_e       state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       send_q, send_d;
    logic             begin_q, begin_d;
    logic [5:0][7:0]  rx_q, rx_d;
    logic [11:0]      x_q, x_d, y_q, y_d, z_q, z_d;
    logic             valid_q, valid_d;
    logic             init_q, init_d;
    logic             ovr_q, ovr_d;
    logic             run_q, run_d;
    logic             tick;
    logic             in_burst;
    logic             last;
    logic             cnt_done;

    function automatic logic [7:0] burst_byte(input logic rd, input logic [2:0] idx);
        return rd ? (idx == 3'd0 ? CMD_READ  : idx == 3'd1 ? REG_XDATA_L   : 8'h00)
                  : (idx == 3'd0 ? CMD_WRITE : idx == 3'd1 ? REG_POWER_CTL : POWER_CTL_VAL);
    endfunction

    acl_rate_timer #(.PERIOD(SAMPLE_PERIOD)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .run_i  (run_q),
        .tick_o (tick)
    );

    assign in_burst = state_q == INIT || state_q == READ;
    assign last     = idx_q == (state_q == READ ? 3'(READ_LEN - 1) : 3'(INIT_LEN - 1));
    assign cnt_done = cnt_q + 32'd1 >= (state_q == STARTUP ? 32'(STARTUP_CYCLES) : 32'(GAP_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STARTUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            send_q  <= '0;
            begin_q <= 1'b0;
            rx_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            valid_q <= 1'b0;
            init_q  <= 1'b0;
            ovr_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            send_q  <= send_d;
            begin_q <= begin_d;
            rx_q    <= rx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            valid_q <= valid_d;
            init_q  <= init_d;
            ovr_q   <= ovr_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            STARTUP:      if (cnt_done) state_d = INIT;
            INIT:         if (end_transmission && last) state_d = GAP_I;
            GAP_I, GAP_R: if (cnt_done) state_d = IDLE;
            IDLE:         if (tick && enable) state_d = READ;
            READ:         if (end_transmission && last) state_d = PUBLISH;
            PUBLISH:      state_d = GAP_R;
            default:      state_d = STARTUP;
        endcase
    end

    always_comb begin
        cnt_d   = (state_d == state_q && (state_q == STARTUP || state_q == GAP_I || state_q == GAP_R))
                  ? cnt_q + 32'd1 : '0;
        idx_d   = idx_q;
        send_d  = send_q;
        begin_d = begin_q;
        rx_d    = rx_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        valid_d = 1'b0;
        init_d  = init_q;
        ovr_d   = tick && state_q != IDLE;
        run_d   = run_q || (state_q == GAP_I && state_d == IDLE);
        if ((state_d == INIT || state_d == READ) && state_d != state_q) begin
            idx_d   = '0;
            send_d  = burst_byte(state_d == READ, 3'd0);
            begin_d = 1'b1;
        end
        if (in_burst && end_transmission) begin
            if (state_q == READ && idx_q >= 3'd2) rx_d[3'(idx_q - 3'd2)] = recieved_data;
            if (last) begin
                begin_d = 1'b0;
                init_d  = init_q || state_q == INIT;
            end else begin
                idx_d  = idx_q + 3'd1;
                send_d = burst_byte(state_q == READ, idx_q + 3'd1);
            end
        end
        // The last data byte lands in rx_d this same cycle, so publish from rx_d.
        if (state_q == READ && state_d == PUBLISH) begin
            x_d     = {rx_d[1][3:0], rx_d[0]};
            y_d     = {rx_d[3][3:0], rx_d[2]};
            z_d     = {rx_d[5][3:0], rx_d[4]};
            valid_d = 1'b1;
        end
    end

    assign send_data          = send_q;
    assign begin_transmission = begin_q;
    assign acl_x              = x_q;
    assign acl_y              = y_q;
    assign acl_z              = z_q;
    assign sample_valid       = valid_q;
    assign init_done          = init_q;
    assign sample_overrun     = ovr_q;

endmodule

// File: tb/tb_acl_sample_sequencer.sv
// tb_acl_sample_sequencer: directed bench with a behavioural SPI byte-stage responder.
module tb_acl_sample_sequencer;

    localparam int BYTE_CYC = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  send_data;
    logic        begin_transmission;
    logic        end_transmission;
    logic [7:0]  recieved_data;
    logic [11:0] acl_x, acl_y, acl_z;
    logic        sample_valid, init_done, sample_overrun;

    int          n_checks = 0;
    int          n_fail = 0;
    int          bi = 0;
    int          bursts = 0;
    int          proto_err = 0;
    int          width_err = 0;
    int          valid_cnt = 0;
    int          ovr_cnt = 0;
    logic        prev_valid = 1'b0;
    logic [7:0]  mosi [8];
    logic [7:0]  resp [8];

    acl_sample_sequencer #(
        .SAMPLE_PERIOD  (300),
        .STARTUP_CYCLES (20),
        .GAP_CYCLES     (64)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .send_data          (send_data),
        .begin_transmission (begin_transmission),
        .end_transmission   (end_transmission),
        .recieved_data      (recieved_data),
        .acl_x              (acl_x),
        .acl_y              (acl_y),
        .acl_z              (acl_z),
        .sample_valid       (sample_valid),
        .init_done          (init_done),
        .sample_overrun     (sample_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // SPI byte stage: one byte per BYTE_CYC cycles, pulse, then re-sample begin two cycles later.
    initial begin
        logic [7:0] cur;
        bit abort;
        end_transmission = 1'b0;
        recieved_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (rst || !begin_transmission) begin
                bi = 0;
                continue;
            end
            if (bi == 0) bursts++;
            cur = send_data;
            if (bi < 8) mosi[bi] = cur;
            abort = 1'b0;
            for (int k = 0; k < BYTE_CYC; k++) begin
                @(posedge clk); #1;
                if (rst) begin
                    abort = 1'b1;
                    break;
                end
                if (send_data !== cur || begin_transmission !== 1'b1) proto_err++;
            end
            if (abort) begin
                bi = 0;
                continue;
            end
            recieved_data = (bi < 8) ? resp[bi] : 8'h00;
            end_transmission = 1'b1;
            @(posedge clk); #1;
            end_transmission = 1'b0;
            bi++;
        end
    end

    always @(negedge clk) begin
        if (sample_valid) valid_cnt++;
        if (sample_valid && prev_valid) width_err++;
        if (sample_overrun) ovr_cnt++;
        prev_valid = sample_valid;
    end

    task automatic startup_delay(input string tag);
        int n;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            n = i;
            if (begin_transmission) break;
        end
        check(tag, n, 20);
    endtask

    task automatic wait_init(input string tag);
        bit ok;
        logic prev_end;
        ok = 1'b0;
        prev_end = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (init_done) begin
                ok = 1'b1;
                break;
            end
            prev_end = end_transmission;
        end
        check({tag, "_seen"}, ok, 1);
        check({tag, "_after_pulse"}, prev_end, 1);
        check({tag, "_bytes"}, bi, 3);
        check({tag, "_b0"}, mosi[0], 8'h0A);
        check({tag, "_b1"}, mosi[1], 8'h2D);
        check({tag, "_b2"}, mosi[2], 8'h02);
    endtask

    task automatic wait_valid(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (sample_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_timeout"}, ok, 1);
    endtask

    initial begin
        bit ok;
        int b0;
        for (int i = 0; i < 8; i++) resp[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_begin", begin_transmission, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_init", init_done, 0);
        check("rst_x", acl_x, 0);
        check("rst_ovr", sample_overrun, 0);
        rst = 1'b0;
        startup_delay("startup_delay");
        wait_init("init");

        // First tick arrives with enable low: nothing should happen.
        repeat (400) @(negedge clk);
        check("dis_bursts", bursts, 1);
        check("dis_ovr", ovr_cnt, 0);

        resp[0] = 8'hAA; resp[1] = 8'h55;
        resp[2] = 8'h34; resp[3] = 8'hF1; resp[4] = 8'hFF;
        resp[5] = 8'h07; resp[6] = 8'h00; resp[7] = 8'h08;
        enable = 1'b1;
        wait_valid("s1");
        check("s1_x", acl_x, 12'h134);
        check("s1_y", acl_y, 12'h7FF);
        check("s1_z", acl_z, 12'h800);
        check("s1_mosi0", mosi[0], 8'h0B);
        check("s1_mosi1", mosi[1], 8'h0E);
        for (int i = 2; i < 8; i++) check($sformatf("s1_mosi%0d", i), mosi[i], 8'h00);
        check("s1_ovr", ovr_cnt, 1);
        @(negedge clk);
        check("s1_valid_1cyc", sample_valid, 0);
        repeat (50) @(negedge clk);
        check("s1_hold_x", acl_x, 12'h134);

        // Second burst: enable dropped once the burst has started, upper nibbles ignored.
        resp[2] = 8'hFF; resp[3] = 8'h0F; resp[4] = 8'h00;
        resp[5] = 8'h00; resp[6] = 8'hAB; resp[7] = 8'h5C;
        b0 = bursts;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bursts != b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("s2_start", ok, 1);
        enable = 1'b0;
        wait_valid("s2");
        check("s2_x", acl_x, 12'hFFF);
        check("s2_y", acl_y, 12'h000);
        check("s2_z", acl_z, 12'hCAB);
        check("s2_ovr", ovr_cnt, 2);

        // Reset in the middle of byte 4 of the next READ burst.
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bi == 4 && begin_transmission) begin
                ok = 1'b1;
                break;
            end
        end
        check("r_mid_burst", ok, 1);
        #2 rst = 1'b1;
        #1;
        check("r_begin_async", begin_transmission, 0);
        check("r_valid_async", sample_valid, 0);
        check("r_init_async", init_done, 0);
        check("r_z_async", acl_z, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        startup_delay("restart_delay");
        wait_init("reinit");
        check("no_partial", valid_cnt, 2);
        check("proto", proto_err, 0);
        check("valid_width", width_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/acl_sample_sequencer.md
Name: acl_sample_sequencer

Overview:
- Byte-level transaction controller sitting directly upstream of the SPI byte interface (spi_interface_acl) for the glove's ADXL362 accelerometer.
- Performs one-time sensor init: write POWER_CTL to measurement mode.
- Then periodically bursts a read of XDATA_L..ZDATA_H and publishes sign-extended 12-bit X/Y/Z samples with a one-cycle valid strobe to the sensor-fusion datapath.

Parameters:
- SAMPLE_PERIOD, 1000000, clk cycles between sample ticks (100 Hz at 100 MHz); must exceed read-burst duration.
- STARTUP_CYCLES, 1000000, delay after reset before init burst (sensor power-up).
- GAP_CYCLES, 16384, minimum idle cycles between bursts; must be ≥ 4*(SPI_CLK_COUNT_MAX+1) of the SPI stage so it has returned to idle.
- REG_POWER_CTL, 8'h2D, init register address.
- POWER_CTL_VAL, 8'h02, init value (measure mode).
- REG_XDATA_L, 8'h0E, first data register address.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- enable  in  1  allow new read bursts
- send_data  out  8  byte to SPI stage
- begin_transmission  out  1  byte request to SPI stage
- end_transmission  in  1  one-cycle byte-done pulse from SPI stage
- recieved_data  in  8  byte shifted in, valid when end_transmission=1
- acl_x  out  12  signed X sample
- acl_y  out  12  signed Y sample
- acl_z  out  12  signed Z sample
- sample_valid  out  1  one-cycle strobe, new X/Y/Z
- init_done  out  1  sticky, init burst complete
- sample_overrun  out  1  one-cycle pulse, tick dropped

Behaviour:
- Interface: one clock, clk; reset rst asynchronous, active-high.
- Reset: all outputs 0. This includes begin_transmission=0 immediately, asynchronously. State STARTUP, all counters 0.
- A reset asserted mid-burst aborts the burst. No partial sample is published.
- States: STARTUP -> INIT -> GAP_I -> IDLE -> READ -> PUBLISH -> GAP_R -> IDLE.
- STARTUP: count STARTUP_CYCLES, then go to INIT with byte_idx=0.
- Burst handshake, used by both INIT and READ:
  - On entry, drive send_data=byte[0] and set begin_transmission=1.
  - begin_transmission stays 1 for the whole burst.
  - On each cycle with end_transmission=1 for byte k that is not the last: next edge drives send_data=byte[k+1] and increments byte_idx. begin_transmission stays high, so the SPI stage sees it in its hold state two cycles after the pulse.
  - On end_transmission of the last byte: next edge drops begin_transmission to 0.
  - send_data changes only on those edges.
- INIT bytes: 8'h0A, REG_POWER_CTL, POWER_CTL_VAL. After the last byte: init_done<=1 and go to GAP_I.
- GAP_I / GAP_R: count GAP_CYCLES, then go to IDLE. The rate timer starts when GAP_I exits.
- Rate timer: free-running from 0 to SAMPLE_PERIOD-1, producing a one-cycle tick at wrap.
  - Tick in IDLE with enable=1: go to READ.
  - Tick in IDLE with enable=0: ignored, no overrun.
  - Tick in any other state after init: sample_overrun pulses and the tick is dropped.
- READ bytes: 8'h0B, REG_XDATA_L, then six 8'h00. recieved_data for bytes 2..7 is captured into buf[0..5] on its end_transmission cycle. Bytes 0 and 1 are discarded.
- PUBLISH: entered on the edge after byte 7's end_transmission. On that edge:
  - acl_x<={buf1[3:0],buf0}, acl_y<={buf3[3:0],buf2}, acl_z<={buf5[3:0],buf4}.
  - sample_valid<=1 for exactly one cycle.
  - Upper nibble bits [7:4] of high bytes are ignored.
- Outputs hold between strobes.
- enable deasserted mid-READ: the burst completes and publishes.
- end_transmission outside INIT/READ: ignored.

Decomposition:
- Package acl_pkg holds:
  - state encoding (STARTUP, INIT, GAP_I, IDLE, READ, PUBLISH, GAP_R);
  - CMD_WRITE=8'h0A, CMD_READ=8'h0B;
  - INIT_LEN=3, READ_LEN=8.
- One sub-module, acl_rate_timer: SAMPLE_PERIOD counter with run input and tick output.

Test Plan (bench instantiates the SPI stage with SPI_CLK_COUNT_MAX=3 and a MISO responder model; STARTUP_CYCLES=20, GAP_CYCLES=64, SAMPLE_PERIOD=2000):
- Reset then release -> after 20 cycles MOSI carries 0x0A,0x2D,0x02 in one chip-select-low burst; init_done rises after the third end_transmission.
- Tick with enable=1, responder returns 0x34,0xF1,0xFF,0x07,0x00,0x08 -> MOSI 0x0B,0x0E + six 0x00; acl_x=12'h134, acl_y=12'h7FF, acl_z=12'h800; sample_valid high exactly one cycle.
- Protocol check during any burst -> begin_transmission never drops before the last end_transmission; send_data stable except on the edge after each pulse; chip select stays low across all bytes.
- SAMPLE_PERIOD=300 (shorter than a burst) -> sample_overrun pulses on a tick during READ/GAP_R; no second burst overlaps.
- enable=0 at tick -> no burst, no overrun; enable dropped during READ -> burst completes and sample_valid fires.
- Assert rst during byte 4 of READ -> begin_transmission=0 and sample_valid=0 asynchronously; after release the sequence restarts from STARTUP and performs init again.
